// File: rtl/pipelined_add_sub.sv
// Streaming WIDTH-bit adder/subtractor with the carry chain split over STAGES registered chunks.
// Build option PIPELINED_ADD_SUB_SATURATE_EN clamps s to the signed limit on overflow.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW  = WIDTH / STAGES;
    localparam int unsigned MSB = WIDTH - 1;

    logic             w_adv;

    // Stage inputs: index 0 is the incoming beat, index k is stage k-1's register.
    logic [WIDTH-1:0] w_in_x [STAGES];
    logic [WIDTH-1:0] w_in_y [STAGES];
    logic [WIDTH-1:0] w_in_s [STAGES];
    logic             w_in_c [STAGES];
    logic             w_in_v [STAGES];
    logic [WIDTH-1:0] w_nx_s [STAGES];

    logic [WIDTH-1:0] r_x [STAGES];
    logic [WIDTH-1:0] r_y [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    logic             w_ovf;
    logic [WIDTH-1:0] w_fin_s;

    // The whole pipeline moves together whenever the output slot is free or being taken.
    assign w_adv     = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

    // Subtraction is x + ~y + 1, so y is inverted once here and carried in that form.
    assign w_in_x[0] = x;
    assign w_in_y[0] = sub ? ~y : y;
    assign w_in_s[0] = '0;
    assign w_in_c[0] = sub | cin;
    assign w_in_v[0] = in_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign w_in_x[k] = r_x[k-1];
        assign w_in_y[k] = r_y[k-1];
        assign w_in_s[k] = r_s[k-1];
        assign w_in_c[k] = r_c[k-1];
        assign w_in_v[k] = r_v[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}}) << (k * CW);

        logic [CW:0]      w_sum;
        logic [WIDTH-1:0] w_ld_s;

        assign w_sum = (CW+1)'(w_in_x[k][k*CW +: CW])
                     + (CW+1)'(w_in_y[k][k*CW +: CW])
                     + (CW+1)'(w_in_c[k]);

        // Splice this stage's chunk into the partially built result.
        assign w_nx_s[k] = (w_in_s[k] & ~CHUNK_MASK) | (WIDTH'(w_sum[CW-1:0]) << (k * CW));

        if (k == STAGES - 1) begin : g_last
            assign w_ld_s = w_fin_s;
        end else begin : g_mid
            assign w_ld_s = w_nx_s[k];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k] <= 1'b0;
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end else if (w_adv) begin
                r_v[k] <= w_in_v[k];
                r_x[k] <= w_in_x[k];
                r_y[k] <= w_in_y[k];
                r_s[k] <= w_ld_s;
                r_c[k] <= w_sum[CW];
            end
        end
    end

    // Overflow: operand signs agree but the result sign differs.
    assign w_ovf = (w_in_x[STAGES-1][MSB] == w_in_y[STAGES-1][MSB])
                && (w_nx_s[STAGES-1][MSB] != w_in_x[STAGES-1][MSB]);

`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'({WIDTH{1'b1}} >> 1);

    assign w_fin_s = w_ovf ? (w_in_x[STAGES-1][MSB] ? ~SAT_POS : SAT_POS) : w_nx_s[STAGES-1];
`else
    assign w_fin_s = w_nx_s[STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=16, STAGES=4) against a signed/unsigned arithmetic model.
module tb_pipelined_add_sub;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;
    exp_t exp_q[$];

    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    logic             held_o;

`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [WIDTH-1:0] EXP_NEG_OVF = 16'h8000;
`else
    localparam logic [WIDTH-1:0] EXP_POS_OVF = 16'h8000;
    localparam logic [WIDTH-1:0] EXP_NEG_OVF = 16'h7FFF;
`endif

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic, signed range check for overflow, unsigned compare for borrow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic sb);
        exp_t e;
        int   us;
        int   ss;
        if (sb) begin
            us  = int'(a) - int'(b);
            ss  = int'($signed(a)) - int'($signed(b));
            e.c = (a >= b);
        end else begin
            us  = int'(a) + int'(b) + int'(ci);
            ss  = int'($signed(a)) + int'($signed(b)) + int'(ci);
            e.c = (us > 65535);
        end
        e.s = 16'(us);
        e.o = (ss > 32767) || (ss < -32768);
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
        if (e.o) e.s = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // One cycle of stimulus with random operands; the expectation is queued on acceptance.
    task automatic drive_cycle(input logic v, input logic ordy);
        @(posedge clk); #1;
        in_valid  = v;
        out_ready = ordy;
        x         = 16'($urandom);
        y         = 16'($urandom);
        cin       = 1'($urandom);
        sub       = 1'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(model(x, y, cin, sub));
            n_acc++;
        end
    endtask

    task automatic single_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic ci, input logic sb, input string nm,
                               input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; x = a; y = b; cin = ci; sub = sb; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(model(a, b, ci, sb));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(STAGES));
        chk({nm, "_s"}, 32'(s), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    // Monitor: handshake rule, stall stability and in-order scoreboard comparison.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || s !== held_s || cout !== held_c || ovf !== held_o) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                             out_valid, s, cout, ovf, held_s, held_c, held_o);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got s=%h with no beat outstanding", s);
                end else begin
                    e = exp_q.pop_front();
                    if (s !== e.s || cout !== e.c || ovf !== e.o) begin
                        errors++;
                        $display("FAIL result: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                                 s, cout, ovf, e.s, e.c, e.o);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held_s = s;
            held_c = cout;
            held_o = ovf;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        int  start;
        logic seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        single_beat(16'h1234, 16'h0FED, 1'b1, 1'b0, "add_basic", 16'h2222, 1'b0, 1'b0);
        single_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_all", 16'h0000, 1'b1, 1'b0);
        single_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf", EXP_POS_OVF, 1'b0, 1'b1);
        single_beat(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        single_beat(16'h8000, 16'h0001, 1'b0, 1'b1, "neg_ovf", EXP_NEG_OVF, 1'b1, 1'b1);

        // Back-pressure: 8 back-to-back beats, output blocked in cycles 5..9.
        start = n_acc;
        for (int c = 0; c < 30; c++) begin
            drive_cycle((n_acc - start) < 8, !(c >= 5 && c <= 9));
            if (c >= 5 && c <= 9) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        chk("bp_beats_sent", 32'(n_acc - start), 32'd8);
        chk("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight, the oldest waiting at the output.
        repeat (3) drive_cycle(1'b1, 1'b0);
        repeat (2) drive_cycle(1'b0, 1'b0);
        chk("mid_rst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b0, 1'b1);
            if (out_valid) seen = 1'b1;
        end
        chk("post_rst_no_stale", 32'(seen), 32'd0);
        single_beat(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "post_rst_first", 16'h1000, 1'b0, 1'b0);

        // Random traffic with random source and sink behaviour.
        start = n_acc;
        cyc = 0;
        while ((n_acc - start) < 10000 && cyc < 60000) begin
            drive_cycle(($urandom % 4) != 0, ($urandom % 4) != 0);
            cyc++;
        end
        chk("rand_beats_accepted", 32'(n_acc - start), 32'd10000);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            drive_cycle(1'b0, 1'b1);
            cyc++;
        end
        chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
